// File: rtl/iic_pkg.sv
// rtl/iic_pkg.sv - shared constants and state encoding for the I2C register-init sequencer
package iic_pkg;

    // Table entry layout: {reg_addr, data}
    localparam int REG_AW  = 16;
    localparam int DATA_W  = 8;
    localparam int ENTRY_W = REG_AW + DATA_W;

    // Register addresses that are table control markers rather than writes
    localparam logic [REG_AW-1:0] END_MARK = 16'hFFFF;
    localparam logic [REG_AW-1:0] DLY_MARK = 16'hFFFE;

    // Watchdog trips once bit WDOG_W of the wait counter sets (2^20 cycles)
    localparam int WDOG_W = 20;

    typedef enum logic [11:0] {
        S_IDLE     = 12'h001,
        S_PWR_WAIT = 12'h002,
        S_FETCH    = 12'h004,
        S_DECODE   = 12'h008,
        S_GAP      = 12'h010,
        S_WR_REQ   = 12'h020,
        S_WR_WAIT  = 12'h040,
        S_RD_REQ   = 12'h080,
        S_RD_WAIT  = 12'h100,
        S_DELAY    = 12'h200,
        S_NEXT     = 12'h400,
        S_DONE     = 12'h800
    } state_t;

endpackage

// File: rtl/iic_cfg_seq_if.sv
// rtl/iic_cfg_seq_if.sv - request/response bundle between the sequencer and the byte-level I2C controller
interface iic_cfg_seq_if;
    logic        w_req;
    logic        r_req;
    logic [7:0]  device_id;
    logic [15:0] reg_addr;
    logic        addr_mode;
    logic [15:0] w_num;
    logic [15:0] r_num;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        ack;
    logic        r_valid;
    logic [7:0]  rd_data;

    modport master (
        output w_req, r_req, device_id, reg_addr, addr_mode, w_num, r_num, wr_data,
        input  wr_done, ack, r_valid, rd_data
    );

    modport slave (
        input  w_req, r_req, device_id, reg_addr, addr_mode, w_num, r_num, wr_data,
        output wr_done, ack, r_valid, rd_data
    );
endinterface

// File: rtl/iic_cfg_rom.sv
// rtl/iic_cfg_rom.sv - synchronous init-table ROM, one-cycle read latency
module iic_cfg_rom
    import iic_pkg::*;
#(
    parameter int                         TBL_AW   = 8,
    parameter int                         DEPTH    = 4,
    // Entry i lives at CONTENTS[i*ENTRY_W +: ENTRY_W]
    parameter logic [DEPTH*ENTRY_W-1:0]   CONTENTS = {24'hFFFF00, 24'hFFFE01, 24'h310303, 24'h300882}
) (
    input  logic               clk,
    input  logic [TBL_AW-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    // Registered read; addresses past the table read back as the end marker
    always_ff @(posedge clk) begin
        if (int'(addr) < DEPTH) begin
            data <= CONTENTS[int'(addr)*ENTRY_W +: ENTRY_W];
        end else begin
            data <= {END_MARK, 8'h00};
        end
    end

endmodule

// File: rtl/iic_cfg_seq.sv
// rtl/iic_cfg_seq.sv - walks a register table and issues single-byte I2C writes with retry and optional verify
module iic_cfg_seq
    import iic_pkg::*;
#(
    parameter logic [7:0] DEVICE_ID = 8'h60,
    parameter bit         ADDR_MODE = 1'b1,
    parameter int         TBL_AW    = 8,
    parameter int         PWR_DLY   = 50000,
    parameter int         DLY_UNIT  = 50000,
    parameter int         MAX_RETRY = 3,
    parameter bit         VERIFY    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [TBL_AW-1:0]  err_idx,
    output logic [TBL_AW-1:0]  tbl_addr,
    input  logic [ENTRY_W-1:0] tbl_data,
    iic_cfg_seq_if.master      bus
);

    state_t             state;
    logic [31:0]        cnt;        // power-up and delay-entry countdown
    logic [WDOG_W:0]    wdog;       // cycles spent waiting on the controller
    logic [7:0]         retry_cnt;
    logic               gap_cnt;
    logic               gap_rd;     // request to issue once the gap expires
    logic [DATA_W-1:0]  rd_byte;
    logic [DATA_W-1:0]  rd_cmp;
    logic [REG_AW-1:0]  ent_addr;
    logic [DATA_W-1:0]  ent_data;
    logic [31:0]        dly_prod;
    logic               xfer_fail;

    assign ent_addr = tbl_data[ENTRY_W-1:DATA_W];
    assign ent_data = tbl_data[DATA_W-1:0];
    assign dly_prod = 32'(ent_data) * 32'(DLY_UNIT);

    // A transfer fails on NACK, watchdog expiry, or a read-back that differs from the written byte
    always_comb begin
        rd_cmp    = bus.r_valid ? bus.rd_data : rd_byte;
        xfer_fail = 1'b0;
        if (state == S_WR_WAIT) begin
            xfer_fail = bus.wr_done ? bus.ack : wdog[WDOG_W];
        end else if (state == S_RD_WAIT) begin
            xfer_fail = bus.wr_done ? (bus.ack || (rd_cmp != bus.wr_data)) : wdog[WDOG_W];
        end
    end

    // Sequencer FSM; every output is registered and request pulses default low
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_idx       <= '0;
            tbl_addr      <= '0;
            cnt           <= '0;
            wdog          <= '0;
            retry_cnt     <= '0;
            gap_cnt       <= 1'b0;
            gap_rd        <= 1'b0;
            rd_byte       <= '0;
            bus.w_req     <= 1'b0;
            bus.r_req     <= 1'b0;
            bus.device_id <= '0;
            bus.reg_addr  <= '0;
            bus.addr_mode <= 1'b0;
            bus.w_num     <= '0;
            bus.r_num     <= '0;
            bus.wr_data   <= '0;
        end else begin
            bus.w_req     <= 1'b0;
            bus.r_req     <= 1'b0;
            done          <= 1'b0;
            bus.device_id <= DEVICE_ID;
            bus.addr_mode <= ADDR_MODE;
            bus.w_num     <= 16'd1;
            bus.r_num     <= 16'd1;
            if (state == S_RD_WAIT && bus.r_valid) begin
                rd_byte <= bus.rd_data;
            end
            if (xfer_fail) begin
                if (int'(retry_cnt) < MAX_RETRY) begin
                    retry_cnt <= retry_cnt + 8'd1;
                    gap_rd    <= 1'b0;
                    gap_cnt   <= 1'b0;
                    state     <= S_GAP;
                end else begin
                    err     <= 1'b1;
                    err_idx <= tbl_addr;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            tbl_addr  <= '0;
                            retry_cnt <= '0;
                            cnt       <= 32'(PWR_DLY);
                            state     <= S_PWR_WAIT;
                        end
                    end
                    S_PWR_WAIT: begin
                        if (cnt <= 32'd1) state <= S_FETCH;
                        else              cnt   <= cnt - 32'd1;
                    end
                    S_FETCH: state <= S_DECODE;
                    S_DECODE: begin
                        bus.reg_addr <= ent_addr;
                        bus.wr_data  <= ent_data;
                        if (ent_addr == END_MARK) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else if (ent_addr == DLY_MARK) begin
                            cnt   <= dly_prod;
                            state <= (dly_prod == 32'd0) ? S_NEXT : S_DELAY;
                        end else begin
                            gap_rd  <= 1'b0;
                            gap_cnt <= 1'b0;
                            state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (!gap_cnt) begin
                            gap_cnt <= 1'b1;
                        end else if (gap_rd) begin
                            bus.r_req <= 1'b1;
                            state     <= S_RD_REQ;
                        end else begin
                            bus.w_req <= 1'b1;
                            state     <= S_WR_REQ;
                        end
                    end
                    S_WR_REQ: begin
                        wdog  <= '0;
                        state <= S_WR_WAIT;
                    end
                    S_WR_WAIT: begin
                        if (bus.wr_done) begin
                            if (VERIFY) begin
                                gap_rd  <= 1'b1;
                                gap_cnt <= 1'b0;
                                state   <= S_GAP;
                            end else begin
                                state <= S_NEXT;
                            end
                        end else begin
                            wdog <= wdog + (WDOG_W+1)'(1);
                        end
                    end
                    S_RD_REQ: begin
                        wdog  <= '0;
                        state <= S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        if (bus.wr_done) state <= S_NEXT;
                        else             wdog  <= wdog + (WDOG_W+1)'(1);
                    end
                    S_DELAY: begin
                        if (cnt <= 32'd1) state <= S_NEXT;
                        else              cnt   <= cnt - 32'd1;
                    end
                    S_NEXT: begin
                        retry_cnt <= '0;
                        if (tbl_addr == '1) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            tbl_addr <= tbl_addr + TBL_AW'(1);
                            state    <= S_FETCH;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_cfg_seq.sv
// tb/tb_iic_cfg_seq.sv - scoreboard bench for the register-init sequencer
module tb_iic_cfg_seq;

    localparam int PWR   = 10;
    localparam int UNIT  = 100;
    localparam int RETRY = 3;
    localparam int AW    = 8;
    localparam int LAT   = 4;

    localparam logic [1:0] EV_W    = 2'd0;
    localparam logic [1:0] EV_R    = 2'd1;
    localparam logic [1:0] EV_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start0, start1;
    logic          busy0, done0, err0, busy1, done1, err1;
    logic [AW-1:0] err_idx0, tbl_addr0, err_idx1, tbl_addr1;
    logic [23:0]   tbl_data0, tbl_data1;
    logic [23:0]   tbl [0:7];
    bit            sel;

    iic_cfg_seq_if bus0();
    iic_cfg_seq_if bus1();

    iic_cfg_seq #(.PWR_DLY(PWR), .DLY_UNIT(UNIT), .MAX_RETRY(RETRY), .TBL_AW(AW), .VERIFY(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .err(err0),
        .err_idx(err_idx0), .tbl_addr(tbl_addr0), .tbl_data(tbl_data0), .bus(bus0)
    );

    iic_cfg_seq #(.PWR_DLY(PWR), .DLY_UNIT(UNIT), .MAX_RETRY(RETRY), .TBL_AW(AW), .VERIFY(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .err(err1),
        .err_idx(err_idx1), .tbl_addr(tbl_addr1), .tbl_data(tbl_data1), .bus(bus1)
    );

    iic_cfg_rom #(.TBL_AW(AW), .DEPTH(2), .CONTENTS({24'hFFFF00, 24'h1234AA})) rom1 (
        .clk(clk), .addr(tbl_addr1), .data(tbl_data1)
    );

    always @(posedge clk) tbl_data0 <= tbl[tbl_addr0[2:0]];

    // Only one instance runs at a time; sel picks which one the model and monitor follow
    logic        m_w_req, m_r_req, m_done, m_busy;
    logic [15:0] m_reg_addr;
    logic [7:0]  m_wr_data;
    assign m_w_req    = sel ? bus1.w_req    : bus0.w_req;
    assign m_r_req    = sel ? bus1.r_req    : bus0.r_req;
    assign m_done     = sel ? done1         : done0;
    assign m_busy     = sel ? busy1         : busy0;
    assign m_reg_addr = sel ? bus1.reg_addr : bus0.reg_addr;
    assign m_wr_data  = sel ? bus1.wr_data  : bus0.wr_data;

    logic       m_wr_done = 1'b0, m_ack = 1'b0, m_r_valid = 1'b0;
    logic [7:0] m_rd_data = 8'h00;
    assign bus0.wr_done = m_wr_done & ~sel;
    assign bus1.wr_done = m_wr_done & sel;
    assign bus0.ack     = m_ack & ~sel;
    assign bus1.ack     = m_ack & sel;
    assign bus0.r_valid = m_r_valid & ~sel;
    assign bus1.r_valid = m_r_valid & sel;
    assign bus0.rd_data = m_rd_data;
    assign bus1.rd_data = m_rd_data;

    bit         ack_q [$];
    logic [7:0] rd_q  [$];
    ev_t        exp_q [$];

    int tests = 0, fails = 0;
    int cyc = 0;
    int busy_rise = -1, first_wreq = -1, done_cyc = -1;
    logic [15:0] hold_addr = 16'h0;
    logic [7:0]  hold_data = 8'h0;
    logic        busy_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: fixed latency, NACK pattern from ack_q, read data from rd_q
    initial begin
        int  m_cnt;
        bit  m_rd;
        logic [7:0] m_wbyte;
        m_cnt = 0; m_rd = 0; m_wbyte = 8'h00;
        forever begin
            @(posedge clk);
            m_wr_done <= 1'b0;
            m_r_valid <= 1'b0;
            m_ack     <= 1'b0;
            if (rst) begin
                m_cnt = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 1 && m_rd) begin
                    m_r_valid <= 1'b1;
                    m_rd_data <= (rd_q.size() > 0) ? rd_q.pop_front() : m_wbyte;
                end
                if (m_cnt == 0) begin
                    m_wr_done <= 1'b1;
                    m_ack     <= (!m_rd && ack_q.size() > 0) ? ack_q.pop_front() : 1'b0;
                end
            end else if (m_w_req) begin
                m_cnt = LAT; m_rd = 0; m_wbyte = m_wr_data;
            end else if (m_r_req) begin
                m_cnt = LAT; m_rd = 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic note(input logic [1:0] kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, expected nothing", kind, m_reg_addr, m_wr_data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind != EV_DONE && (e.addr != m_reg_addr || (kind == EV_W && e.data != m_wr_data)))) begin
                fails++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, expected kind=%0d addr=%h data=%h",
                         kind, m_reg_addr, m_wr_data, e.kind, e.addr, e.data);
            end
        end
    endtask

    // Monitor: pops the scoreboard on each request/done and checks operands are held until wr_done
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (m_w_req) begin
                note(EV_W);
                hold_addr = m_reg_addr; hold_data = m_wr_data;
                if (first_wreq < 0) first_wreq = cyc;
            end
            if (m_r_req) begin
                note(EV_R);
                hold_addr = m_reg_addr; hold_data = m_wr_data;
            end
            if (m_done) begin
                note(EV_DONE);
                done_cyc = cyc;
            end
            if (m_wr_done) begin
                check("reg_addr_held", m_reg_addr, hold_addr);
                check("wr_data_held", m_wr_data, hold_data);
            end
            if (m_busy && !busy_q) busy_rise = cyc;
        end
        busy_q = m_busy;
    end

    task automatic push_ev(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic kick();
        busy_rise = -1; first_wreq = -1; done_cyc = -1;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((sel ? busy1 : busy0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, required low", name, n);
        end
    endtask

    task automatic finish_test(input string name);
        repeat (30) @(negedge clk);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        exp_q.delete(); ack_q.delete(); rd_q.delete();
    endtask

    task automatic load_tbl(input logic [23:0] e0, input logic [23:0] e1, input logic [23:0] e2, input logic [23:0] e3);
        for (int i = 0; i < 8; i++) tbl[i] = 24'hFFFF00;
        tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
    endtask

    initial begin
        int d, n;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
        load_tbl(24'hFFFF00, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        repeat (3) @(negedge clk);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_tbl_addr", tbl_addr0, 0);
        check("rst_w_req", bus0.w_req, 0);
        check("rst_device_id", bus0.device_id, 0);
        rst = 1'b0;
        @(negedge clk);
        check("device_id", bus0.device_id, 8'h60);
        check("addr_mode", bus0.addr_mode, 1);
        check("w_num", bus0.w_num, 1);
        check("r_num", bus0.r_num, 1);

        // Two plain writes then end marker
        load_tbl(24'h300882, 24'h310303, 24'hFFFF00, 24'hFFFF00);
        push_ev(EV_W, 16'h3008, 8'h82); push_ev(EV_W, 16'h3103, 8'h03); push_ev(EV_DONE, 16'h0, 8'h0);
        kick();
        wait_idle(300, "basic");
        check("basic_first_wreq_latency", first_wreq - busy_rise, PWR + 4);
        check("basic_err", err0, 0);
        finish_test("basic");

        // Entry 1 NACKs twice then ACKs
        ack_q = '{1'b0, 1'b1, 1'b1, 1'b0};
        push_ev(EV_W, 16'h3008, 8'h82);
        for (int i = 0; i < 3; i++) push_ev(EV_W, 16'h3103, 8'h03);
        push_ev(EV_DONE, 16'h0, 8'h0);
        kick();
        wait_idle(300, "retry");
        check("retry_err", err0, 0);
        finish_test("retry");

        // Entry 2 NACKs on every attempt: retries exhausted
        load_tbl(24'h300882, 24'h310303, 24'h400011, 24'hFFFF00);
        ack_q = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        push_ev(EV_W, 16'h3008, 8'h82); push_ev(EV_W, 16'h3103, 8'h03);
        for (int i = 0; i < 4; i++) push_ev(EV_W, 16'h4000, 8'h11);
        kick();
        wait_idle(400, "fail");
        check("fail_err", err0, 1);
        check("fail_err_idx", err_idx0, 2);
        check("fail_busy", busy0, 0);
        finish_test("fail");

        // Delay entry of 3 units, plus a start pulse while busy that must be ignored
        load_tbl(24'hFFFE03, 24'hFFFF00, 24'hFFFF00, 24'hFFFF00);
        push_ev(EV_DONE, 16'h0, 8'h0);
        kick();
        check("err_cleared_on_start", err0, 0);
        repeat (50) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_idle(1000, "delay");
        // FETCH+DECODE before the delay, NEXT+FETCH+DECODE after it
        d = done_cyc - busy_rise - (PWR + 5);
        tests++;
        if (done_cyc < 0 || d < 3 * UNIT - 2 || d > 3 * UNIT + 2) begin
            fails++;
            $display("FAIL delay_cycles: got %0d, expected %0d +/- 2", d, 3 * UNIT);
        end
        finish_test("delay");

        // Reset while waiting on the controller, then a fresh run
        load_tbl(24'h300882, 24'h310303, 24'hFFFF00, 24'hFFFF00);
        push_ev(EV_W, 16'h3008, 8'h82);
        kick();
        n = 0;
        while (first_wreq < 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_run_wreq_seen", int'(first_wreq >= 0), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy0, 0);
        check("midrst_w_req", bus0.w_req, 0);
        check("midrst_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        push_ev(EV_W, 16'h3008, 8'h82); push_ev(EV_W, 16'h3103, 8'h03); push_ev(EV_DONE, 16'h0, 8'h0);
        kick();
        wait_idle(300, "restart");
        check("restart_first_wreq_latency", first_wreq - busy_rise, PWR + 4);
        check("restart_err", err0, 0);
        finish_test("restart");

        // Verify: first read-back mismatches, second matches
        sel = 1'b1;
        @(negedge clk);
        rd_q = '{8'h55, 8'hAA};
        push_ev(EV_W, 16'h1234, 8'hAA); push_ev(EV_R, 16'h1234, 8'hAA);
        push_ev(EV_W, 16'h1234, 8'hAA); push_ev(EV_R, 16'h1234, 8'hAA);
        push_ev(EV_DONE, 16'h0, 8'h0);
        kick();
        wait_idle(300, "verify");
        check("verify_err", err1, 0);
        finish_test("verify");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iic_cfg_seq.md
Name: iic_cfg_seq

Overview:
- Register-initialisation sequencer sitting directly upstream of the byte-level I2C controller (iic_ctrl).
- Walks an external table of {reg_addr, data} entries and issues one single-byte write request per entry to the controller.
- Optionally reads each register back and compares it; retries entries that were not acknowledged.
- Reports busy, done, error and the failing index to system control (e.g. camera/EEPROM bring-up).

Parameters:
- DEVICE_ID, 8'h60, 7-bit slave address in [7:1], bit0 = 0; driven on device_id.
- ADDR_MODE, 1, 1 = 16-bit register address, 0 = 8-bit; driven on addr_mode.
- TBL_AW, 8, table address width; maximum 2^TBL_AW entries.
- PWR_DLY, 50000, clk cycles to wait after start before the first entry.
- DLY_UNIT, 50000, clk cycles per unit of a delay entry.
- MAX_RETRY, 3, retries per entry after a NACK or a verify mismatch.
- VERIFY, 0, 1 = read back and compare after each write.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a sequence; ignored while busy
- busy  out  1  high from start accept until done/err
- done  out  1  one-cycle pulse, sequence completed without error
- err  out  1  sticky; set when an entry exhausts its retries; cleared by the next accepted start
- err_idx  out  TBL_AW  index of the failing entry
- tbl_addr  out  TBL_AW  table read address
- tbl_data  in  24  {reg_addr[15:0], data[7:0]}; valid 1 cycle after tbl_addr changes
- w_req, r_req  out  1  one-cycle request pulses to the controller
- device_id  out  8  DEVICE_ID; read direction is added by the controller
- reg_addr  out  16  register address of the current entry
- addr_mode  out  1  ADDR_MODE
- w_num, r_num  out  16  constant 16'd1
- wr_data  out  8  data byte of the current entry
- wr_done  in  1  controller completion pulse (write or read)
- ack  in  1  controller flag, 1 = NACK seen during the transfer; sampled with wr_done
- r_valid  in  1  read byte valid
- rd_data  in  8  read byte

Behaviour:
- Reset: all outputs 0; tbl_addr = 0; state IDLE.
- reg_addr/wr_data are registered and stay stable from the request until wr_done.
- State machine:
  - IDLE: on start, clear err, set idx=0 and busy=1, go to PWR_WAIT.
  - PWR_WAIT: count PWR_DLY cycles, then go to FETCH.
  - FETCH: drive tbl_addr=idx; wait 1 cycle, then go to DECODE.
  - DECODE: latch tbl_data.
    - reg_addr==16'hFFFF is the end marker: go to DONE.
    - reg_addr==16'hFFFE is a delay entry: go to DELAY.
    - Otherwise go to WR_REQ.
  - WR_REQ: w_req=1 for exactly one cycle, then go to WR_WAIT.
  - WR_WAIT: on wr_done:
    - ack=1: retry or fail.
    - Otherwise: go to RD_REQ if VERIFY, else NEXT.
  - RD_REQ: r_req=1 for one cycle, then go to RD_WAIT.
  - RD_WAIT:
    - On r_valid, latch rd_data.
    - On wr_done: mismatch or ack=1 means retry or fail; otherwise go to NEXT.
  - DELAY: count data*DLY_UNIT cycles, then go to NEXT. data=0 means zero wait.
  - NEXT: idx+1. If idx was at its maximum value (wrap), go to DONE; otherwise go to FETCH.
  - Retry or fail: retry counter < MAX_RETRY means increment it and go back to WR_REQ; otherwise set err, err_idx=idx and go to IDLE. The retry counter clears on every NEXT.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- A 2-cycle GAP is inserted before every WR_REQ/RD_REQ. The controller returns to IDLE one cycle after wr_done and samples req only in IDLE.
- Requests are never asserted while waiting.
- Watchdog: if WR_WAIT or RD_WAIT exceeds 2^20 cycles, treat it as a NACK.
- The delay counter is 32-bit; the product data*DLY_UNIT must not overflow.
- Simultaneous start and busy: start is ignored.
- rst mid-operation: return to IDLE on the next edge. No req is issued after that edge; the in-flight controller transfer is left to the controller's own reset.
- Latency: the first w_req appears PWR_DLY+4 cycles after start (PWR_WAIT, FETCH, DECODE, GAP×2).

Decomposition:
- Package iic_pkg holds:
  - sentinel constants END_MARK=16'hFFFF and DLY_MARK=16'hFFFE;
  - state encodings (one-hot, 12 states);
  - the table entry field widths.
- One natural sub-module: iic_cfg_rom, a synchronous table ROM with 1-cycle read latency, instantiated beside the sequencer rather than inside it.

Test Plan:
- Table {0x3008:0x82, 0x3103:0x03, END}, controller model always ACKs, PWR_DLY=10 -> exactly 2 w_req pulses with matching reg_addr/wr_data, then a done pulse; err=0.
- Entry 1 NACKs twice then ACKs, MAX_RETRY=3 -> 4 w_req pulses total, then done.
- Entry 2 NACKs 4 times -> err=1, err_idx=2, busy=0, no done pulse, no further req.
- Table {0xFFFE:0x03, END}, DLY_UNIT=100 -> 300±2 cycles between DECODE and done; no w_req.
- VERIFY=1, model returns 0x55 for written 0xAA on the first read and 0xAA on the second -> write/read/write/read sequence, then done.
- rst asserted during WR_WAIT, then start again -> busy restarts, and the first w_req comes PWR_DLY+4 cycles after the new start with idx=0.
